// File: rtl/conn_block_pkg.sv
// Shared sizing helpers and encodings for the parametrised connection block.
// Every derived width is computed here so the top and config chain agree.
package conn_block_pkg;

    typedef enum logic {
        UNCFG = 1'b0,
        CFG   = 1'b1
    } cfg_state_e;

    localparam int SEL_NONE = 0;
    localparam int SEL_BASE = 1;

    // Width of a select able to name n_choices sources plus the "none" code
    function automatic int sel_width_f(input int n_choices);
        return $clog2(n_choices + 1);
    endfunction

    function automatic int ntrk_f(input int ws, input int wd);
        return 2 * ws + 2 * wd;
    endfunction

    function automatic int cfg_len_f(input int ntrk, input int nclb,
                                     input int clbin, input int clbout);
        return nclb * clbin * sel_width_f(ntrk) + ntrk * sel_width_f(nclb * clbout);
    endfunction

    function automatic int cfg_words_f(input int cfg_len, input int shift_w);
        return (cfg_len + shift_w - 1) / shift_w;
    endfunction

endpackage

// File: rtl/cfg_shift_chain.sv
// Word-serial, double-buffered configuration chain: shadow shift register,
// word counter, length-checked commit into the active register.
module cfg_shift_chain
    import conn_block_pkg::*;
#(
    parameter  int LEN_WORDS = 49,
    parameter  int SHIFT_W   = 4,
    localparam int TOTAL     = LEN_WORDS * SHIFT_W,
    localparam int CNT_W     = $clog2(LEN_WORDS + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               set_in,
    input  logic [SHIFT_W-1:0] shift_in,
    output logic [SHIFT_W-1:0] shift_out,
    output logic [TOTAL-1:0]   active,
    output logic               cfg_valid,
    output logic               cfg_err
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LEN_WORDS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(LEN_WORDS + 1);

    logic [TOTAL-1:0] shadow_r;
    logic [TOTAL-1:0] shadow_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             commit_ok_s;
    cfg_state_e       state_r;

    // Next shadow/count including a shift in the same cycle as set_in
    always_comb begin
        shadow_next_s = shadow_r;
        cnt_next_s    = cnt_r;
        if (cen) begin
            shadow_next_s = TOTAL'({shadow_r, shift_in});
            if (cnt_r == CNT_SAT) begin
                cnt_next_s = cnt_r;
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else begin
            shadow_next_s = shadow_r;
            cnt_next_s    = cnt_r;
        end
        commit_ok_s = set_in && (cnt_next_s == CNT_FULL);
    end

    // Shadow, counter, commit and the UNCFG/CFG state machine
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r  <= '0;
            cnt_r     <= '0;
            shift_out <= '0;
            active    <= '0;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
            state_r   <= UNCFG;
        end else begin
            shadow_r  <= shadow_next_s;
            shift_out <= shadow_next_s[TOTAL-1 -: SHIFT_W];
            if (set_in) begin
                cnt_r <= '0;
                if (commit_ok_s) begin
                    active  <= shadow_next_s;
                    cfg_err <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else begin
                cnt_r <= cnt_next_s;
            end
            case (state_r)
                UNCFG: begin
                    if (commit_ok_s) begin
                        state_r   <= CFG;
                        cfg_valid <= 1'b1;
                    end else begin
                        state_r   <= UNCFG;
                        cfg_valid <= 1'b0;
                    end
                end
                CFG: begin
                    state_r   <= CFG;
                    cfg_valid <= 1'b1;
                end
                default: begin
                    state_r   <= UNCFG;
                    cfg_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/param_connection_block.sv
// Connection block: configurable input/output muxes between CLBs and track
// bundles, plus fixed carry chaining. Configuration state lives in cfg_shift_chain.
module param_connection_block
    import conn_block_pkg::*;
#(
    parameter  int WS        = 4,
    parameter  int WD        = 8,
    parameter  int NCLB      = 2,
    parameter  int CLBIN     = 10,
    parameter  int CLBOUT    = 5,
    parameter  int CARRY     = 1,
    parameter  int SHIFT_W   = 4,
    localparam int NTRK      = ntrk_f(WS, WD),
    localparam int NSRC      = NCLB * CLBOUT,
    localparam int ISELW     = sel_width_f(NTRK),
    localparam int OSELW     = sel_width_f(NSRC),
    localparam int CFG_LEN   = cfg_len_f(NTRK, NCLB, CLBIN, CLBOUT),
    localparam int CFG_WORDS = cfg_words_f(CFG_LEN, SHIFT_W),
    localparam int ACT_W     = CFG_WORDS * SHIFT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cen,
    input  logic                     set_in,
    input  logic [SHIFT_W-1:0]       shift_in,
    output logic [SHIFT_W-1:0]       shift_out,
    output logic                     cfg_valid,
    output logic                     cfg_err,
    input  logic [NTRK-1:0]          track_in,
    output logic [NTRK-1:0]          track_out,
    output logic [NTRK-1:0]          track_oe,
    input  logic [NSRC-1:0]          clb_output,
    output logic [NCLB*CLBIN-1:0]    clb_input,
    input  logic [NCLB*CARRY-1:0]    clb_cout,
    output logic [NCLB*CARRY-1:0]    clb_cin,
    input  logic [CARRY-1:0]         carry_in,
    output logic [CARRY-1:0]         carry_out
);

    localparam int               OBASE   = NCLB * CLBIN * ISELW;
    localparam logic [OSELW-1:0] OSEL_LO = OSELW'(SEL_BASE);
    localparam logic [OSELW-1:0] OSEL_HI = OSELW'(NSRC);

    logic [ACT_W-1:0]      active_s;
    logic [2**ISELW-1:0]   trk_pad_s;
    logic [2**OSELW-1:0]   clb_pad_s;

    cfg_shift_chain #(
        .LEN_WORDS (CFG_WORDS),
        .SHIFT_W   (SHIFT_W)
    ) u_cfg (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .set_in    (set_in),
        .shift_in  (shift_in),
        .shift_out (shift_out),
        .active    (active_s),
        .cfg_valid (cfg_valid),
        .cfg_err   (cfg_err)
    );

    // Source vectors indexed directly by select code; out-of-range codes hit zero padding
    always_comb begin
        trk_pad_s = '0;
        clb_pad_s = '0;
        trk_pad_s[NTRK+SEL_BASE-1:SEL_BASE] = track_in;
        clb_pad_s[NSRC+SEL_BASE-1:SEL_BASE] = clb_output;
    end

    // CLB input muxes
    always_comb begin
        clb_input = '0;
        for (int p = 0; p < NCLB * CLBIN; p++) begin
            clb_input[p] = trk_pad_s[active_s[p*ISELW +: ISELW]];
        end
    end

    // Track output muxes; any invalid select disables the driver
    always_comb begin
        track_oe  = '0;
        track_out = '0;
        for (int t = 0; t < NTRK; t++) begin
            if ((active_s[OBASE + t*OSELW +: OSELW] >= OSEL_LO) &&
                (active_s[OBASE + t*OSELW +: OSELW] <= OSEL_HI)) begin
                track_oe[t]  = 1'b1;
                track_out[t] = clb_pad_s[active_s[OBASE + t*OSELW +: OSELW]];
            end else begin
                track_oe[t]  = 1'b0;
                track_out[t] = 1'b0;
            end
        end
    end

    assign clb_cin[0 +: CARRY] = carry_in;
    for (genvar k = 1; k < NCLB; k++) begin : g_carry
        assign clb_cin[k*CARRY +: CARRY] = clb_cout[(k-1)*CARRY +: CARRY];
    end
    assign carry_out = clb_cout[(NCLB-1)*CARRY +: CARRY];

endmodule

// File: tb/tb_param_connection_block.sv
// Self-checking bench for param_connection_block: randomized images and inputs
// checked against a select-table / word-queue reference model.
module tb_param_connection_block;

    localparam int NTRK = 24, ISELW = 5, OSELW = 4, NCLB = 2, CLBIN = 10, CLBOUT = 5;
    localparam int SW = 4, CFG_WORDS = 49, IMG_W = 196, OBASE = 100;
    localparam int NPIN = NCLB * CLBIN, NSRC = NCLB * CLBOUT;

    logic clk, rst, cen, set_in;
    logic [SW-1:0]   shift_in, shift_out;
    logic            cfg_valid, cfg_err;
    logic [NTRK-1:0] track_in, track_out, track_oe;
    logic [NSRC-1:0] clb_output;
    logic [NPIN-1:0] clb_input;
    logic [1:0]      clb_cout, clb_cin;
    logic [0:0]      carry_in, carry_out;

    param_connection_block dut (
        .clk(clk), .rst(rst), .cen(cen), .set_in(set_in),
        .shift_in(shift_in), .shift_out(shift_out),
        .cfg_valid(cfg_valid), .cfg_err(cfg_err),
        .track_in(track_in), .track_out(track_out), .track_oe(track_oe),
        .clb_output(clb_output), .clb_input(clb_input),
        .clb_cout(clb_cout), .clb_cin(clb_cin),
        .carry_in(carry_in), .carry_out(carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: select tables, committed image, last CFG_WORDS shifted words
    int              in_sel [NPIN];
    int              out_sel[NTRK];
    logic [IMG_W-1:0] m_active;
    bit              m_valid, m_err;
    int              m_cnt;
    logic [SW-1:0]   m_shadow[$];
    logic [IMG_W-1:0] img;
    logic [SW-1:0]   load_words[CFG_WORDS];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IMG_W-1:0] build_img();
        logic [IMG_W-1:0] r = '0;
        for (int p = 0; p < NPIN; p++) r[p*ISELW +: ISELW] = ISELW'(in_sel[p]);
        for (int t = 0; t < NTRK; t++) r[OBASE + t*OSELW +: OSELW] = OSELW'(out_sel[t]);
        return r;
    endfunction

    function automatic logic [SW-1:0] word_of(input logic [IMG_W-1:0] im, input int j);
        return im[(CFG_WORDS-1-j)*SW +: SW];
    endfunction

    function automatic logic [IMG_W-1:0] shadow_img();
        logic [IMG_W-1:0] r = '0;
        for (int q = 0; q < CFG_WORDS; q++) r[(CFG_WORDS-1-q)*SW +: SW] = m_shadow[q];
        return r;
    endfunction

    task automatic model_reset();
        m_active = '0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
        m_shadow.delete();
        for (int q = 0; q < CFG_WORDS; q++) m_shadow.push_back('0);
    endtask

    task automatic rand_inputs();
        track_in   = NTRK'($urandom);
        clb_output = NSRC'($urandom);
        clb_cout   = 2'($urandom_range(0, 3));
        carry_in   = 1'($urandom_range(0, 1));
    endtask

    task automatic check_all(input string tag);
        logic [NPIN-1:0] e_in;
        logic [NTRK-1:0] e_oe, e_out;
        int s;
        for (int p = 0; p < NPIN; p++) begin
            s = int'(m_active[p*ISELW +: ISELW]);
            e_in[p] = (s >= 1 && s <= NTRK) ? track_in[s-1] : 1'b0;
        end
        for (int t = 0; t < NTRK; t++) begin
            s = int'(m_active[OBASE + t*OSELW +: OSELW]);
            e_oe[t]  = (s >= 1 && s <= NSRC);
            e_out[t] = (s >= 1 && s <= NSRC) ? clb_output[s-1] : 1'b0;
        end
        check({tag, "/valid"}, 64'(cfg_valid), 64'(m_valid));
        check({tag, "/err"}, 64'(cfg_err), 64'(m_err));
        check({tag, "/shift_out"}, 64'(shift_out), 64'(m_shadow[0]));
        check({tag, "/clb_input"}, 64'(clb_input), 64'(e_in));
        check({tag, "/track_oe"}, 64'(track_oe), 64'(e_oe));
        check({tag, "/track_out"}, 64'(track_out), 64'(e_out));
        check({tag, "/clb_cin"}, 64'(clb_cin), 64'({clb_cout[0], carry_in}));
        check({tag, "/carry_out"}, 64'(carry_out), 64'(clb_cout[1]));
    endtask

    task automatic cycle(input bit c, input bit s, input logic [SW-1:0] w, input string tag);
        cen = c; set_in = s; shift_in = w;
        @(posedge clk); #1;
        cen = 1'b0; set_in = 1'b0;
        if (c) begin
            m_shadow.push_back(w);
            void'(m_shadow.pop_front());
            if (m_cnt < CFG_WORDS + 1) m_cnt++;
        end
        if (s) begin
            if (m_cnt == CFG_WORDS) begin
                m_active = shadow_img(); m_valid = 1'b1; m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            m_cnt = 0;
        end
        rand_inputs();
        #1;
        check_all(tag);
    endtask

    task automatic load(input logic [IMG_W-1:0] im, input int n, input bit set_last, input string tag);
        for (int j = 0; j < n; j++) cycle(1'b1, set_last && (j == n-1), word_of(im, j), tag);
    endtask

    task automatic random_tables();
        for (int p = 0; p < NPIN; p++) in_sel[p] = $urandom_range(0, 31);
        for (int t = 0; t < NTRK; t++) out_sel[t] = $urandom_range(0, 15);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; set_in = 1'b0; shift_in = '0;
        track_in = '0; clb_output = '0; clb_cout = 2'b00; carry_in = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        #2;
        check("rst/track_oe", 64'(track_oe), 64'd0);
        check("rst/clb_input", 64'(clb_input), 64'd0);
        check("rst/clb_cin", 64'(clb_cin), 64'b01);
        check("rst/carry_out", 64'(carry_out), 64'd0);
        check("rst/cfg_valid", 64'(cfg_valid), 64'd0);
        check("rst/shift_out", 64'(shift_out), 64'd0);
        #9 rst = 1'b1;
        rand_inputs(); #1;
        check_all("idle");

        // CLB0 input0 <- track 2, track 0 <- clb_output[6]; commit on its own cycle
        random_tables(); in_sel[0] = 3; out_sel[0] = 7;
        img = build_img();
        load(img, CFG_WORDS, 1'b0, "load1");
        cycle(1'b0, 1'b1, '0, "commit1");
        check("commit1/valid", 64'(cfg_valid), 64'd1);
        check("commit1/in0", 64'(clb_input[0]), 64'(track_in[2]));
        check("commit1/oe0", 64'(track_oe[0]), 64'd1);
        check("commit1/out0", 64'(track_out[0]), 64'(clb_output[6]));

        // Out-of-range output select, committed together with the last shift
        random_tables(); out_sel[0] = 15;
        img = build_img();
        load(img, CFG_WORDS, 1'b1, "load2");
        check("sel15/oe0", 64'(track_oe[0]), 64'd0);

        // Short load is rejected; routing held
        random_tables();
        img = build_img();
        load(img, CFG_WORDS - 1, 1'b0, "short");
        cycle(1'b0, 1'b1, '0, "short_set");
        check("short/err", 64'(cfg_err), 64'd1);
        check("short/valid", 64'(cfg_valid), 64'd1);

        // Clean reload clears the error; then readback in load order
        random_tables();
        img = build_img();
        for (int j = 0; j < CFG_WORDS; j++) load_words[j] = word_of(img, j);
        load(img, CFG_WORDS, 1'b0, "load3");
        cycle(1'b0, 1'b1, '0, "commit3");
        check("commit3/err", 64'(cfg_err), 64'd0);
        for (int j = 0; j < CFG_WORDS; j++) begin
            check("readback", 64'(shift_out), 64'(load_words[j]));
            cycle(1'b1, 1'b0, SW'($urandom), "readback_shift");
        end
        cycle(1'b0, 1'b1, '0, "commit_rb");

        // Long load (one word too many) is rejected
        random_tables();
        img = build_img();
        load(img, CFG_WORDS + 1, 1'b1, "long");
        check("long/err", 64'(cfg_err), 64'd1);

        // Reset during word 20 of a load over a committed config
        load(img, CFG_WORDS, 1'b1, "load4");
        random_tables();
        img = build_img();
        load(img, 19, 1'b0, "load5");
        cen = 1'b1; shift_in = word_of(img, 19);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("midrst/valid", 64'(cfg_valid), 64'd0);
        check("midrst/err", 64'(cfg_err), 64'd0);
        check("midrst/track_oe", 64'(track_oe), 64'd0);
        check("midrst/track_out", 64'(track_out), 64'd0);
        check("midrst/clb_input", 64'(clb_input), 64'd0);
        check("midrst/shift_out", 64'(shift_out), 64'd0);
        cen = 1'b0;
        #3 rst = 1'b1;
        @(posedge clk); #1;
        rand_inputs(); #1;
        check_all("post_rst");

        // Recovery after reset
        random_tables();
        img = build_img();
        load(img, CFG_WORDS, 1'b1, "load6");
        check("load6/valid", 64'(cfg_valid), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_connection_block.md
# param_connection_block

Parametrised connection block for the fabric tile: routes NCLB adjacent CLBs to unidirectional single/double track bundles through configurable muxes, and carries a word-serial, double-buffered configuration chain. Configuration shifts into a shadow register and is committed to the active register only on a length-checked `set_in`, so routing never sees partially loaded bits. It replaces the fixed two-CLB, bit-serial connection block in the tile and chains with neighbours through `shift_in`/`shift_out`.

## Interface
- WS, 4, single-wire tracks per side
- WD, 8, double-wire tracks per side
- NCLB, 2, CLBs served
- CLBIN, 10, inputs per CLB
- CLBOUT, 5, outputs per CLB
- CARRY, 1, carry width per CLB
- SHIFT_W, 4, config bits shifted per `cen` cycle
- Derived: NTRK=2*WS+2*WD; ISELW=clog2(NTRK+1); OSELW=clog2(NCLB*CLBOUT+1); CFG_LEN=NCLB*CLBIN*ISELW+NTRK*OSELW; CFG_WORDS=ceil(CFG_LEN/SHIFT_W). Defaults: 24, 5, 4, 196, 49.

- clk  in  1  clock; single clock domain, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cen  in  1  shift one SHIFT_W word this cycle
- set_in  in  1  commit request
- shift_in  in  SHIFT_W  config word in
- shift_out  out  SHIFT_W  config word out (top word of shadow), registered
- cfg_valid  out  1  active config committed since reset
- cfg_err  out  1  sticky: last commit rejected
- track_in  in  NTRK  track values, order single0, single1, double0, double1
- track_out  out  NTRK  driven track values
- track_oe  out  NTRK  per-track drive enable
- clb_output  in  NCLB*CLBOUT  CLB outputs, CLB k at [k*CLBOUT +: CLBOUT]
- clb_input  out  NCLB*CLBIN  CLB inputs
- clb_cout  in  NCLB*CARRY  carry outs
- clb_cin  out  NCLB*CARRY  carry ins
- carry_in  in  CARRY  chain carry from south neighbour
- carry_out  out  CARRY  chain carry to north neighbour

## Operation
- Shadow: CFG_WORDS*SHIFT_W bits. On `cen`, shift left by SHIFT_W with `shift_in` into the LSBs. `shift_out` = shadow top SHIFT_W bits after the update.
- Field map in the active register, from bit 0: CLB k input i select at (k*CLBIN+i)*ISELW; then track t output select at NCLB*CLBIN*ISELW + t*OSELW. Bits above CFG_LEN are padding and are ignored.
- Input select v: 0 drives 0; 1..NTRK selects track_in[v-1]; larger values drive 0.
- Output select v: 0 gives oe=0 and out=0; 1..NCLB*CLBOUT gives oe=1 and out=clb_output[v-1]; larger values behave as 0.
- Carry: clb_cin[k] = k==0 ? carry_in : clb_cout[k-1]; carry_out = clb_cout[NCLB-1]. Combinational and unconfigured.
- Word counter `cnt` counts `cen` cycles since the last `set_in`. It saturates at CFG_WORDS+1.
- Two-state FSM, UNCFG and CFG. It starts in UNCFG, where active=0.
- `set_in` with cnt_next==CFG_WORDS: active<=shadow_next, cfg_valid<=1, cfg_err<=0, FSM goes to CFG.
- `set_in` with cnt_next!=CFG_WORDS: no commit; active, FSM and cfg_valid are held; cfg_err<=1.
- Either outcome of `set_in` clears cnt to 0.
- cnt_next and shadow_next include any shift performed in the same cycle.
- Readback: shadow holds its contents after a commit, so CFG_WORDS further shifts return the image word-for-word on `shift_out`, first-shifted word first.

## Timing
- Reset: shadow=0, active=0, cnt=0, cfg_valid=0, cfg_err=0, shift_out=0.
- Consequences of reset: track_oe=0, track_out=0, clb_input=0. Carry outputs follow their inputs.
- Shift latency: a word shifted at edge n appears on `shift_out` after edge n+CFG_WORDS-1.
- Commit latency: routing changes the cycle after the `set_in` edge. Muxes are combinational from active.
- Reset asserted mid-load or mid-commit wins unconditionally; no partial commit survives.
- `cen` with `set_in` low never alters active.

## Structure
- Package `conn_block_pkg` holds: clog2-based width functions; derived-size functions; select encodings SEL_NONE=0 and SEL_BASE=1.
- Sub-module `cfg_shift_chain` (params LEN_WORDS, SHIFT_W) contains: the shadow register, cnt, commit check, active register, and the cfg_valid/cfg_err flags.
- The top level holds only the mux arrays and carry wiring.

## Test plan
- Reset, no config → all track_oe=0, clb_input=0; carry_in=1 with clb_cout=2'b00 gives clb_cin=2'b01, carry_out=0.
- Shift 49 words setting CLB0 input0 select=3, then set_in → next cycle cfg_valid=1 and clb_input[0] follows track_in[2].
- Track 0 output select=7 after commit → track_oe[0]=1, track_out[0]=clb_output[6]. Select 15 → oe=0.
- 48 words then set_in → cfg_err=1, cfg_valid and routing unchanged. A following clean 49-word load + set_in → cfg_err=0.
- cen and set_in together on word 49 → commit accepted. After commit, 49 more shifts return the image on shift_out in load order.
- rst low during word 20 of a load over a committed config → all outputs to reset values, cfg_valid=0.
